// File: rtl/mmio_io_bridge_pkg.sv
// Shared I/O window definitions for the MMIO bridge; assembler test programs
// use the same offsets and base address.
package mmio_io_bridge_pkg;

    localparam logic [3:0] OFF_LED  = 4'd0;
    localparam logic [3:0] OFF_SW   = 4'd1;
    localparam logic [3:0] OFF_EDGE = 4'd2;
    localparam logic [3:0] OFF_CYC  = 4'd3;

    localparam int unsigned IO_BASE_DEFAULT = 'hFF0;
    localparam int          CYC_W           = 32;

endpackage

// File: rtl/mmio_io_bridge_debounce.sv
// One switch channel: two-flop synchroniser followed by a stable-count debouncer.
module sw_debounce #(
    parameter int DEB_CYCLES = 1000
) (
    input  logic clock,
    input  logic reset,
    input  logic sw_raw,
    output logic deb,
    output logic rise
);

    localparam int CW = (DEB_CYCLES > 2) ? $clog2(DEB_CYCLES) : 1;

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;
    logic          accept;

    // accept marks the cycle deb takes the synchronised value; rise lines up with it
    assign accept = (sync2 != deb) && (cnt == CW'(DEB_CYCLES - 1));
    assign rise   = accept & sync2;

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            deb   <= 1'b0;
        end else begin
            sync1 <= sw_raw;
            sync2 <= sync1;
            if (sync2 == deb) begin
                cnt <= '0;
            end else if (accept) begin
                deb <= sync2;
                cnt <= '0;
            end else begin
                cnt <= cnt + CW'(1);
            end
        end
    end

endmodule

// File: rtl/mmio_io_bridge.sv
// Data-memory bridge: a 16-word I/O window at IO_BASE holds LED, switch, edge-flag
// and cycle-counter registers; every other access passes straight through to RAM.
module mmio_io_bridge
    import mmio_io_bridge_pkg::*;
#(
    parameter int                ADDR_W     = 12,
    parameter int                DATA_W     = 32,
    parameter int                NUM_SW     = 16,
    parameter int                NUM_LED    = 16,
    parameter int                DEB_CYCLES = 1000,
    parameter logic [ADDR_W-1:0] IO_BASE    = ADDR_W'(IO_BASE_DEFAULT)
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               wren,
    input  logic [ADDR_W-1:0]  address_dmem,
    input  logic [DATA_W-1:0]  data,
    output logic [DATA_W-1:0]  q_dmem,
    output logic               ram_wEn,
    output logic [ADDR_W-1:0]  ram_addr,
    output logic [DATA_W-1:0]  ram_dataIn,
    input  logic [DATA_W-1:0]  ram_dataOut,
    input  logic [NUM_SW-1:0]  SW,
    output logic [NUM_LED-1:0] LED
);

    logic              io_hit;
    logic              io_we;
    logic [3:0]        off;
    logic [NUM_LED-1:0] led_q;
    logic [NUM_SW-1:0] sw_in;
    logic [NUM_SW-1:0] sw_rise;
    logic [NUM_SW-1:0] edge_q;
    logic [NUM_SW-1:0] edge_clr;
    logic [CYC_W-1:0]  cyc_q;
    logic [DATA_W-1:0] io_rdata;
    logic [DATA_W-1:0] io_rdata_q;
    logic              io_hit_q;

    assign io_hit     = (address_dmem[ADDR_W-1:4] == IO_BASE[ADDR_W-1:4]);
    assign off        = address_dmem[3:0];
    assign io_we      = wren & io_hit;
    assign ram_wEn    = wren & ~io_hit;
    assign ram_addr   = address_dmem;
    assign ram_dataIn = data;
    assign LED        = led_q;

    for (genvar i = 0; i < NUM_SW; i++) begin : g_sw
        sw_debounce #(
            .DEB_CYCLES (DEB_CYCLES)
        ) u_deb (
            .clock  (clock),
            .reset  (reset),
            .sw_raw (SW[i]),
            .deb    (sw_in[i]),
            .rise   (sw_rise[i])
        );
    end

    assign edge_clr = (io_we && off == OFF_EDGE) ? data[NUM_SW-1:0] : '0;

    // A new rising edge outranks a same-cycle clear; a write to CYC outranks the increment.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            led_q  <= '0;
            edge_q <= '0;
            cyc_q  <= '0;
        end else begin
            if (io_we && off == OFF_LED) begin
                led_q <= data[NUM_LED-1:0];
            end
            edge_q <= (edge_q & ~edge_clr) | sw_rise;
            if (io_we && off == OFF_CYC) begin
                cyc_q <= '0;
            end else begin
                cyc_q <= cyc_q + CYC_W'(1);
            end
        end
    end

    always_comb begin
        io_rdata = '0;
        case (off)
            OFF_LED:  io_rdata = DATA_W'(led_q);
            OFF_SW:   io_rdata = DATA_W'(sw_in);
            OFF_EDGE: io_rdata = DATA_W'(edge_q);
            OFF_CYC:  io_rdata = DATA_W'(cyc_q);
            default:  io_rdata = '0;
        endcase
    end

    // Read data is captured from pre-write register values so both paths have one-cycle latency.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            io_hit_q   <= 1'b0;
            io_rdata_q <= '0;
        end else begin
            io_hit_q   <= io_hit;
            io_rdata_q <= io_rdata;
        end
    end

    assign q_dmem = io_hit_q ? io_rdata_q : ram_dataOut;

endmodule

// File: tb/tb_mmio_io_bridge.sv
// Directed and randomized checks of mmio_io_bridge against a cycle-level reference
// model built from the register-map rules, with a behavioural RAM on the RAM port.
module tb_mmio_io_bridge;

    localparam int         DEB     = 4;
    localparam logic [11:0] IO_BASE = 12'hFF0;
    localparam logic [11:0] A_LED   = IO_BASE;
    localparam logic [11:0] A_SW    = IO_BASE + 12'd1;
    localparam logic [11:0] A_EDGE  = IO_BASE + 12'd2;
    localparam logic [11:0] A_CYC   = IO_BASE + 12'd3;

    logic        clock = 1'b0;
    logic        reset;
    logic        wren;
    logic [11:0] address_dmem;
    logic [31:0] data;
    logic [31:0] q_dmem;
    logic        ram_wEn;
    logic [11:0] ram_addr;
    logic [31:0] ram_dataIn;
    logic [31:0] ram_dataOut = '0;
    logic [15:0] SW;
    logic [15:0] LED;

    always #5 clock = ~clock;

    mmio_io_bridge #(
        .ADDR_W     (12),
        .DATA_W     (32),
        .NUM_SW     (16),
        .NUM_LED    (16),
        .DEB_CYCLES (DEB),
        .IO_BASE    (IO_BASE)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .wren         (wren),
        .address_dmem (address_dmem),
        .data         (data),
        .q_dmem       (q_dmem),
        .ram_wEn      (ram_wEn),
        .ram_addr     (ram_addr),
        .ram_dataIn   (ram_dataIn),
        .ram_dataOut  (ram_dataOut),
        .SW           (SW),
        .LED          (LED)
    );

    // Behavioural synchronous RAM, read-before-write
    logic [31:0] ram_mem [0:4095];
    always @(posedge clock) begin
        if (ram_wEn) ram_mem[ram_addr] <= ram_dataIn;
        ram_dataOut <= ram_mem[ram_addr];
    end

    // Reference model state
    logic [15:0] led_m, swin_m, edge_m;
    logic [31:0] cyc_m, q_m;
    logic [15:0] samp_q[$];
    logic [15:0] syn_q[$];
    logic [31:0] mem_ref [0:4095];
    int vectors = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        led_m  = '0;
        swin_m = '0;
        edge_m = '0;
        cyc_m  = '0;
        samp_q.delete();
        syn_q.delete();
        samp_q.push_back(16'h0);
        samp_q.push_back(16'h0);
    endtask

    // One bus cycle: drive, check the combinational RAM strobe, advance the model, clock, check.
    task automatic step(input logic w, input logic [11:0] a, input logic [31:0] d);
        logic        hit;
        logic [31:0] rd;
        logic [15:0] sync2, new_deb, clr;
        bit          all_diff;
        wren = w;
        address_dmem = a;
        data = d;
        hit = (a[11:4] == IO_BASE[11:4]);
        #1;
        chk("ram_wEn", 32'(ram_wEn), 32'(w & ~hit));
        case (a[3:0])
            4'd0:    rd = 32'(led_m);
            4'd1:    rd = 32'(swin_m);
            4'd2:    rd = 32'(edge_m);
            4'd3:    rd = cyc_m;
            default: rd = 32'h0;
        endcase
        q_m = hit ? rd : mem_ref[a];
        // switch seen by the debouncer this cycle is the value presented two edges ago
        sync2 = samp_q[samp_q.size() - 2];
        samp_q.push_back(SW);
        if (samp_q.size() > 4) void'(samp_q.pop_front());
        syn_q.push_back(sync2);
        if (syn_q.size() > DEB) void'(syn_q.pop_front());
        new_deb = swin_m;
        for (int b = 0; b < 16; b++) begin
            if (syn_q.size() == DEB) begin
                all_diff = 1'b1;
                for (int j = 0; j < DEB; j++)
                    if (syn_q[j][b] == swin_m[b]) all_diff = 1'b0;
                if (all_diff) new_deb[b] = ~swin_m[b];
            end
        end
        clr = (w && hit && a[3:0] == 4'd2) ? d[15:0] : 16'h0;
        edge_m = (edge_m & ~clr) | (new_deb & ~swin_m);
        swin_m = new_deb;
        cyc_m = (w && hit && a[3:0] == 4'd3) ? 32'h0 : cyc_m + 32'd1;
        if (w && hit && a[3:0] == 4'd0) led_m = d[15:0];
        if (w && !hit) mem_ref[a] = d;
        @(posedge clock);
        #1;
        chk("led", 32'(LED), 32'(led_m));
        chk("q_dmem", q_dmem, q_m);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [11:0] a;
        reset = 1'b1;
        wren = 1'b0;
        address_dmem = '0;
        data = '0;
        SW = '0;
        model_reset();
        repeat (3) @(posedge clock);
        #1;
        chk("reset_led", 32'(LED), 32'h0);
        chk("reset_q", q_dmem, ram_dataOut);
        #3 reset = 1'b0;

        // Populate the RAM addresses used by later loads
        for (int i = 0; i < 16; i++) step(1'b1, 12'(i), $urandom);

        // LED store and readback
        step(1'b1, A_LED, 32'h0000A5A5);
        chk("t1_led", 32'(LED), 32'h0000A5A5);
        step(1'b0, A_LED, 32'h0);
        chk("t1_q", q_dmem, 32'h0000A5A5);

        // RAM pass-through
        step(1'b1, 12'h010, 32'h00001234);
        step(1'b0, 12'h010, 32'h0);
        chk("t2_q", q_dmem, 32'h00001234);

        // Bouncing switch never accepted, then a held level is
        for (int c = 0; c < 20; c++) begin
            if (c % 2 == 0) SW[3] = ~SW[3];
            step(1'b0, A_SW, 32'h0);
        end
        chk("t3_bounce", 32'(q_dmem[3]), 32'h0);
        SW[3] = 1'b1;
        for (int k = 0; k < 8; k++) step(1'b0, A_SW, 32'h0);
        chk("t3_swin", 32'(q_dmem[3]), 32'h1);
        step(1'b0, A_EDGE, 32'h0);
        chk("t3_edge", 32'(q_dmem[3]), 32'h1);

        // Clear racing a new rise: the rise keeps the flag set
        step(1'b1, A_EDGE, 32'h8);
        SW[3] = 1'b0;
        repeat (8) step(1'b0, A_SW, 32'h0);
        SW[3] = 1'b1;
        repeat (5) step(1'b0, A_SW, 32'h0);
        step(1'b1, A_EDGE, 32'h8);
        step(1'b0, A_EDGE, 32'h0);
        chk("t4_setwins", 32'(q_dmem[3]), 32'h1);
        step(1'b1, A_EDGE, 32'h8);
        step(1'b0, A_EDGE, 32'h0);
        chk("t4_clear", 32'(q_dmem[3]), 32'h0);

        // Cycle counter cleared by a write, then read back after 10 cycles
        step(1'b1, A_CYC, 32'hDEAD_BEEF);
        repeat (10) step(1'b0, 12'h000, 32'h0);
        step(1'b0, A_CYC, 32'h0);
        chk("t5_cyc", q_dmem, 32'd10);

        // Randomized mix of I/O and RAM traffic with wandering switches
        for (int n = 0; n < 400; n++) begin
            if ($urandom_range(0, 9) == 0) SW = 16'($urandom);
            case ($urandom_range(0, 2))
                0:       a = IO_BASE + 12'($urandom_range(0, 15));
                1:       a = IO_BASE + 12'($urandom_range(0, 3));
                default: a = 12'($urandom_range(0, 15));
            endcase
            step(1'($urandom_range(0, 1)), a, $urandom);
        end

        // Asynchronous reset mid-debounce, right after an LED write
        SW = 16'hFFFF;
        repeat (2) step(1'b0, A_SW, 32'h0);
        step(1'b1, A_LED, 32'h00005A5A);
        #2 reset = 1'b1;
        #1;
        chk("t6_led", 32'(LED), 32'h0);
        chk("t6_q", q_dmem, ram_dataOut);
        model_reset();
        #3 reset = 1'b0;
        step(1'b0, IO_BASE + 12'd9, 32'h0);
        chk("t6_q9", q_dmem, 32'h0);
        step(1'b0, A_SW, 32'h0);
        chk("t6_sw", q_dmem, 32'h0);
        step(1'b0, A_CYC, 32'h0);
        chk("t6_cyc", q_dmem, 32'd2);
        repeat (8) step(1'b0, A_SW, 32'h0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
